// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared constants for the scanned seven-segment driver: hex glyph table,
// the dark segment pattern and counter width helpers.
package sevenseg_scan_driver_pkg;

  // Active-high glyphs, bit6..0 = gfedcba, indexed by nibble value.
  localparam logic [0:15][6:0] HEX_SEG = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int prescaler_width(input int div);
    return cnt_width(div);
  endfunction

  function automatic int idx_width(input int num_digits);
    return cnt_width(num_digits);
  endfunction

endpackage

// File: rtl/sevenseg_scan_driver_hex7seg_lut.sv
// Combinational nibble to active-high seven-segment glyph lookup.
module hex7seg_lut
  import sevenseg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment driver: shadow-latched digits scanned onto a
// shared segment bus with per-digit blanking and leading-zero suppression.
module sevenseg_scan_driver
  import sevenseg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV            = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int PW = prescaler_width(DIV);
  localparam int IW = idx_width(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] data_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   blank_sh;

  logic [NUM_DIGITS-1:0]   zero_from;
  logic [NUM_DIGITS-1:0]   sel;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    cur_zero;
  logic                    dark;
  logic [6:0]              lut_seg;

  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
      idx       <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_sh  <= '0;
      dp_sh    <= '0;
      blank_sh <= '0;
    end else if (load) begin
      data_sh  <= data;
      dp_sh    <= dp_in;
      blank_sh <= blank_mask;
    end
  end

  // zero_from[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run          = run & (data_sh[4*i +: 4] == 4'h0);
      zero_from[i] = run;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_zero  = 1'b0;
    sel       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = data_sh[4*i +: 4];
        cur_dp    = dp_sh[i];
        cur_blank = blank_sh[i];
        cur_zero  = zero_from[i];
        sel[i]    = 1'b1;
      end
    end
  end

  // Digit 0 is exempt from leading-zero suppression so a zero value still shows.
  assign dark = cur_blank | (lz_blank & cur_zero & (idx != '0));

  hex7seg_lut u_lut (
    .nibble (cur_nib),
    .seg    (lut_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= '0;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b0;
    end else begin
      an_q  <= dark ? '0 : sel;
      seg_q <= dark ? SEG_OFF : lut_seg;
      dp_q  <= ~dark & cur_dp;
    end
  end

  assign an  = AN_ACTIVE_LOW  ? ~an_q  : an_q;
  assign seg = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp  = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver: an active-high and an active-low
// instance share stimulus; a cycle model pushes expected outputs each edge.
module tb_sevenseg_scan_driver;

  localparam int N = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [4*N-1:0] data;
  logic [N-1:0]  dp_in;
  logic [N-1:0]  blank_mask;
  logic          lz_blank;

  logic [N-1:0]  an_h, an_l;
  logic [6:0]    seg_h, seg_l;
  logic          dp_h, dp_l;

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .NUM_DIGITS(N), .DIV(D), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut_h (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_blank(lz_blank),
    .an(an_h), .seg(seg_h), .dp(dp_h)
  );

  sevenseg_scan_driver #(
    .NUM_DIGITS(N), .DIV(D), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_l (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_blank(lz_blank),
    .an(an_l), .seg(seg_l), .dp(dp_l)
  );

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  int             m_pre;
  int             m_idx;
  logic [4*N-1:0] m_data;
  logic [N-1:0]   m_dp;
  logic [N-1:0]   m_blank;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Expected active-high outputs produced by the coming edge.
  function automatic exp_t model_out();
    exp_t e;
    logic [4*N-1:0] upper;
    logic is_dark;
    e = '0;
    if (!rst) begin
      upper   = m_data >> (4 * m_idx);
      is_dark = m_blank[m_idx] || (lz_blank && m_idx != 0 && upper == '0);
      if (!is_dark) begin
        e.an[m_idx] = 1'b1;
        e.seg       = ref_seg(upper[3:0]);
        e.dp        = m_dp[m_idx];
      end
    end
    return e;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_pre = 0; m_idx = 0; m_data = '0; m_dp = '0; m_blank = '0;
    end else begin
      if (load) begin
        m_data = data; m_dp = dp_in; m_blank = blank_mask;
      end
      if (m_pre == D - 1) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % N;
      end else begin
        m_pre++;
      end
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    total++;
    assert ({an_h, seg_h, dp_h} === e) else begin
      bad++;
      $error("[TB] FAIL scan_hi t=%0t observed=%h expected=%h", $time, {an_h, seg_h, dp_h}, e);
    end
    total++;
    assert ({an_l, seg_l, dp_l} === ~e) else begin
      bad++;
      $error("[TB] FAIL scan_lo t=%0t observed=%h expected=%h", $time, {an_l, seg_l, dp_l}, ~e);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      sb.push_back(model_out());
      @(posedge clk);
      model_step();
      #1;
      checkOutput();
    end
  endtask

  task automatic checkDirect(input string tag, input logic [N-1:0] an_e,
                             input logic [6:0] seg_e, input logic dp_e);
    total++;
    assert ({an_h, seg_h, dp_h} === {an_e, seg_e, dp_e}) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, {an_h, seg_h, dp_h}, {an_e, seg_e, dp_e});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; dp_in = '0; blank_mask = '0; lz_blank = 1'b0;
    m_pre = 0; m_idx = 0; m_data = '0; m_dp = '0; m_blank = '0;
    $display("[TB] reset");
    applyStimulus(3);
    checkDirect("reset_state", 4'b0000, 7'h00, 1'b0);

    $display("[TB] free-running scan");
    rst = 1'b0;
    applyStimulus(1);
    checkDirect("edge1_digit0", 4'b0001, 7'h3F, 1'b0);
    applyStimulus(3);
    checkDirect("edge4_digit0", 4'b0001, 7'h3F, 1'b0);
    applyStimulus(1);
    checkDirect("edge5_digit1", 4'b0010, 7'h3F, 1'b0);
    applyStimulus(12);
    checkDirect("edge17_wrap", 4'b0001, 7'h3F, 1'b0);

    $display("[TB] load A3F0 with dp on digit2");
    data = 16'hA3F0; dp_in = 4'b0100; load = 1'b1;
    applyStimulus(1);
    load = 1'b0;
    applyStimulus(16);

    $display("[TB] leading-zero suppression");
    lz_blank = 1'b1; data = 16'h0070; load = 1'b1;
    applyStimulus(1);
    load = 1'b0;
    applyStimulus(16);
    data = 16'h0000; load = 1'b1;
    applyStimulus(1);
    load = 1'b0;
    applyStimulus(16);
    lz_blank = 1'b0;

    $display("[TB] blank mask on digit0");
    data = 16'h1234; dp_in = 4'b0001; blank_mask = 4'b0001; load = 1'b1;
    applyStimulus(1);
    load = 1'b0;
    applyStimulus(16);

    $display("[TB] load held high");
    blank_mask = 4'b0000; dp_in = 4'b0000; load = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data = 16'(k * 16'h1357);
      applyStimulus(1);
    end
    load = 1'b0;
    applyStimulus(4);

    $display("[TB] load coinciding with idx advance");
    while (!(m_pre == D - 1 && m_idx == 0)) applyStimulus(1);
    data = 16'h1111; load = 1'b1;
    applyStimulus(1);
    load = 1'b0;
    applyStimulus(1);
    checkDirect("load_on_advance", 4'b0010, 7'h06, 1'b0);
    applyStimulus(8);

    $display("[TB] reset mid-scan");
    while (m_idx != 2) applyStimulus(1);
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    checkDirect("mid_reset", 4'b0000, 7'h00, 1'b0);
    total++;
    assert ({an_l, seg_l, dp_l} === {4'b1111, 7'h7F, 1'b1}) else begin
      bad++;
      $error("[TB] FAIL mid_reset_lo observed=%h expected=%h", {an_l, seg_l, dp_l}, {4'b1111, 7'h7F, 1'b1});
    end
    rst = 1'b0;
    applyStimulus(4);
    checkDirect("restart_digit0", 4'b0001, 7'h3F, 1'b0);
    applyStimulus(1);
    checkDirect("restart_digit1", 4'b0010, 7'h3F, 1'b0);
    applyStimulus(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
